// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus for seq_divider.
interface seq_divider_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned VW = 8
);
    logic          start;
    logic          en;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div0;

    // Requester side: issues operations and steps the divider
    modport master (
        output start, en, dividend, divisor,
        input  busy, done, quotient, remainder, div0
    );

    // Divider side
    modport slave (
        input  start, en, dividend, divisor,
        output busy, done, quotient, remainder, div0
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per enabled clock.
// Optional feature macro: DIV_SIGNED_EN (two's complement operands, extra FIX state).
module seq_divider #(
    parameter int unsigned DW = 16,
    parameter int unsigned VW = 8
) (
    input  logic         clk,
    input  logic         clr,
    seq_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(DW + 1);
    localparam int unsigned PW = VW + 1;
    localparam int unsigned RW = VW + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] r_q, r_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] d_q, d_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          div0_q, div0_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [RW-1:0] r_wide;
    logic [PW-1:0] r_sub;
    logic [PW-1:0] r_step;
    logic [DW-1:0] q_step;
    logic          ge;
    logic [DW-1:0] a_mag;
    logic [VW-1:0] b_mag;

`ifdef DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    // Operand magnitudes; most-negative values stay correct as unsigned magnitudes
    always_comb begin
        a_mag = bus.dividend[DW-1] ? DW'(DW'(0) - bus.dividend) : bus.dividend;
        b_mag = bus.divisor[VW-1]  ? VW'(VW'(0) - bus.divisor)  : bus.divisor;
    end
`else
    // Unsigned operands are their own magnitudes
    always_comb begin
        a_mag = bus.dividend;
        b_mag = bus.divisor;
    end
`endif

    // One restoring step: shift in next dividend bit, subtract if it fits
    always_comb begin
        r_wide = {r_q, q_q[DW-1]};
        ge     = (r_wide >= RW'(d_q));
        r_sub  = PW'(r_wide[PW-1:0] - PW'(d_q));
        r_step = ge ? r_sub : r_wide[PW-1:0];
        q_step = {q_q[DW-2:0], ge};
    end

    // Next-state and next-register values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div0_d  = div0_q;
`ifdef DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    if (bus.divisor == VW'(0)) begin
                        quo_d   = '1;
                        rem_d   = bus.dividend[VW-1:0];
                        div0_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        div0_d  = 1'b0;
                        q_d     = a_mag;
                        d_d     = b_mag;
                        r_d     = '0;
                        cnt_d   = CW'(DW);
`ifdef DIV_SIGNED_EN
                        qneg_d  = bus.dividend[DW-1] ^ bus.divisor[VW-1];
                        rneg_d  = bus.dividend[DW-1];
`endif
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.en) begin
                    q_d   = q_step;
                    r_d   = r_step;
                    cnt_d = CW'(cnt_q - CW'(1));
                    if (cnt_q == CW'(1)) begin
`ifdef DIV_SIGNED_EN
                        state_d = S_FIX;
`else
                        quo_d   = q_step;
                        rem_d   = r_step[VW-1:0];
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef DIV_SIGNED_EN
            S_FIX: begin
                if (bus.en) begin
                    quo_d   = qneg_q ? DW'(DW'(0) - q_q) : q_q;
                    rem_d   = rneg_q ? VW'(VW'(0) - r_q[VW-1:0]) : r_q[VW-1:0];
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div0_q  <= div0_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.div0      = div0_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
    localparam int unsigned DW = 16;
    localparam int unsigned VW = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = DW + 2;
`else
    localparam int LAT = DW + 1;
`endif

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   total = 0;
    int   bad   = 0;

    seq_divider_if #(.DW(DW), .VW(VW)) bus();

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division; signed build truncates toward zero
    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic z, output int lat);
`ifdef DIV_SIGNED_EN
        int sa;
        int sb;
`endif
        if (b == 8'd0) begin
            q = 16'hFFFF; r = a[7:0]; z = 1'b1; lat = 1;
        end else begin
            z = 1'b0; lat = LAT;
`ifdef DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = 16'(sa / sb);
            r  = 8'(sa % sb);
`else
            q = a / 16'(b);
            r = 8'(a % 16'(b));
`endif
        end
    endfunction

    // Issue one operation with en held high; n = edges from accept to first done sample
    task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r,
                         output logic z, output int n);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        bus.en       = 1'b1;
        tick();
        n = 1;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.en = 1'b0; bus.dividend = '0; bus.divisor = '0;
        tick(); tick();
        total++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div0} !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b q=%h r=%h z=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div0);
        end
        clr = 1'b1;
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        logic [15:0] q; logic [7:0] r; logic z; int n;
        do_op(16'd100, 8'd7, q, r, z, n);
        total++;
        if (q !== 16'd14 || r !== 8'd2 || z !== 1'b0 || n != LAT) begin
            bad++;
            $display("FAIL dir_100_7 got q=%h r=%h z=%b n=%0d want q=000e r=02 z=0 n=%0d", q, r, z, n, LAT);
        end
        do_op(16'd5, 8'd9, q, r, z, n);
        total++;
        if (q !== 16'd0 || r !== 8'd5 || z !== 1'b0 || n != LAT) begin
            bad++;
            $display("FAIL dir_5_9 got q=%h r=%h z=%b n=%0d want q=0000 r=05 z=0 n=%0d", q, r, z, n, LAT);
        end
`ifdef DIV_SIGNED_EN
        do_op(16'hFF9C, 8'd7, q, r, z, n);
        total++;
        if (q !== 16'hFFF2 || r !== 8'hFE || z !== 1'b0 || n != 18) begin
            bad++;
            $display("FAIL dir_neg100_7 got q=%h r=%h z=%b n=%0d want q=fff2 r=fe z=0 n=18", q, r, z, n);
        end
        do_op(16'h8000, 8'hFF, q, r, z, n);
        total++;
        if (q !== 16'h8000 || r !== 8'h00 || z !== 1'b0) begin
            bad++;
            $display("FAIL dir_minneg got q=%h r=%h z=%b want q=8000 r=00 z=0", q, r, z);
        end
`else
        do_op(16'hFFFF, 8'hFF, q, r, z, n);
        total++;
        if (q !== 16'h0101 || r !== 8'h00 || z !== 1'b0 || n != 17) begin
            bad++;
            $display("FAIL dir_ffff_ff got q=%h r=%h z=%b n=%0d want q=0101 r=00 z=0 n=17", q, r, z, n);
        end
`endif
    endtask

    task automatic test_div0();
        logic [15:0] q; logic [7:0] r; logic z; int n;
        do_op(16'h1234, 8'd0, q, r, z, n);
        total++;
        if (q !== 16'hFFFF || r !== 8'h34 || z !== 1'b1 || n != 1) begin
            bad++;
            $display("FAIL div0 got q=%h r=%h z=%b n=%0d want q=ffff r=34 z=1 n=1", q, r, z, n);
        end
        // Next non-zero accept clears the flag
        do_op(16'd50, 8'd5, q, r, z, n);
        total++;
        if (z !== 1'b0 || q !== 16'd10 || r !== 8'd0) begin
            bad++;
            $display("FAIL div0_clear got q=%h r=%h z=%b want q=000a r=00 z=0", q, r, z);
        end
    endtask

    task automatic test_hold();
        logic [15:0] q; logic [7:0] r; logic z; int n;
        do_op(16'd100, 8'd7, q, r, z, n);
        bus.dividend = 16'h1234; bus.divisor = 8'h56; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 16'd14 || bus.remainder !== 8'd2) begin
            bad++;
            $display("FAIL hold_while_busy got busy=%b done=%b q=%h r=%h want busy=1 done=0 q=000e r=02",
                     bus.busy, bus.done, bus.quotient, bus.remainder);
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin tick(); n++; end
    endtask

    task automatic test_stall();
        int n;
        bus.dividend = 16'd100; bus.divisor = 8'd7; bus.start = 1'b1; bus.en = 1'b1;
        tick();
        n = 1;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && n < 200) begin
            bus.en = !(n >= 5 && n <= 7);
            if (n == 6) begin
                bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 8'd3;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            n++;
        end
        bus.en = 1'b1;
        total++;
        if (n != LAT + 3 || bus.quotient !== 16'd14 || bus.remainder !== 8'd2) begin
            bad++;
            $display("FAIL stall got n=%0d q=%h r=%h want n=%0d q=000e r=02", n, bus.quotient, bus.remainder, LAT + 3);
        end
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse got done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] q; logic [7:0] r; logic z; int n;
        logic seen;
        bus.dividend = 16'd100; bus.divisor = 8'd7; bus.start = 1'b1; bus.en = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        clr = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div0} !== 27'd0) begin
            bad++;
            $display("FAIL reset_mid got busy=%b done=%b q=%h r=%h z=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div0);
        end
        #1;
        clr = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done got activity=%b want 0", seen);
        end
        do_op(16'd9, 8'd3, q, r, z, n);
        total++;
        if (q !== 16'd3 || r !== 8'd0 || z !== 1'b0 || n != LAT) begin
            bad++;
            $display("FAIL rerun_9_3 got q=%h r=%h z=%b n=%0d want q=0003 r=00 z=0 n=%0d", q, r, z, n, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bus.dividend = 16'd9; bus.divisor = 8'd3; bus.start = 1'b1; bus.en = 1'b1;
        tick();
        n = 1;
        bus.dividend = 16'd5; bus.divisor = 8'd0;
        while (bus.done !== 1'b1 && n < 200) begin tick(); n++; end
        total++;
        if (n != LAT || bus.quotient !== 16'd3 || bus.remainder !== 8'd0 || bus.div0 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first got n=%0d q=%h r=%h z=%b want n=%0d q=0003 r=00 z=0",
                     n, bus.quotient, bus.remainder, bus.div0, LAT);
        end
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.quotient !== 16'hFFFF || bus.remainder !== 8'h05 || bus.div0 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_div0 got done=%b q=%h r=%h z=%b want done=1 q=ffff r=05 z=1",
                     bus.done, bus.quotient, bus.remainder, bus.div0);
        end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] a, q, eq; logic [7:0] b, r, er; logic z, ez; int n, elat;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if (i % 5 == 0) a = 16'($urandom_range(0, 255));
            model(a, b, eq, er, ez, elat);
            do_op(a, b, q, r, z, n);
            total++;
            if (q !== eq || r !== er || z !== ez || n != elat) begin
                bad++;
                $display("FAIL rand_%0d a=%h b=%h got q=%h r=%h z=%b n=%0d want q=%h r=%h z=%b n=%0d",
                         i, a, b, q, r, z, n, eq, er, ez, elat);
            end
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div0();
        test_hold();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
